// File: rtl/regwrite_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regwrite_pkg;

   localparam int WB_ADDR_W = 5;
   localparam int WB_DATA_W = 32;
   localparam int WB_CNT_W  = 8;

   localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } wr_state_t;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/mux5bit2to1.sv
// 5-bit 2:1 destination-register mux: op=0 selects a, op=1 selects b.
module Mux5Bit2To1 (
   input  logic [4:0] a,
   input  logic [4:0] b,
   input  logic       op,
   output logic [4:0] y
);

   assign y = op ? b : a;

endmodule

// File: rtl/regwrite_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] valid,
   output logic [1:0] grant,
   output logic       gnt_idx
);

   logic last_grant;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
         else
            grant = valid;
      end
   end

   assign gnt_idx = grant[1];

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (|grant)
         last_grant <= gnt_idx;
   end

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
module regwrite_arbiter
   import regwrite_pkg::*;
#(
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W,
   parameter int CNT_W  = WB_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              mux_op,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready,
   output logic [CNT_W-1:0]  conflict_cnt
);

   wr_state_t         state;
   logic              can_accept;
   logic [1:0]        grant;
   logic              gnt_idx;
   logic              any_grant;
   logic              mux_op_q;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              do_write;

   // A write slot frees up in the same cycle the regfile drains it, giving back-to-back writes.
   assign can_accept = (state == IDLE) || wr_ready;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .enable  (can_accept && !reset),
      .valid   ({req1_valid, req0_valid}),
      .grant   (grant),
      .gnt_idx (gnt_idx)
   );

   assign any_grant  = |grant;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign mux_op     = any_grant ? gnt_idx : mux_op_q;

   Mux5Bit2To1 u_dst_mux (
      .a  (req0_addr),
      .b  (req1_addr),
      .op (mux_op),
      .y  (sel_addr)
   );

   assign sel_data = gnt_idx ? req1_data : req0_data;
   // Writes to $zero are consumed but never reach the regfile.
   assign do_write = any_grant && (sel_addr != ZERO_REG);
   assign wr_valid = (state == PEND);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wr_addr      <= '0;
         wr_data      <= '0;
         mux_op_q     <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         if (do_write) begin
            state   <= PEND;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end else if ((state == PEND) && wr_ready) begin
            state <= IDLE;
         end
         if (any_grant)
            mux_op_q <= gnt_idx;
         if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed self-checking bench for regwrite_arbiter with hand-computed expectations.
module tb_regwrite_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        mux_op, wr_valid, wr_ready;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [7:0]  conflict_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regwrite_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_addr    (req0_addr),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_addr    (req1_addr),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .mux_op       (mux_op),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .conflict_cnt (conflict_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; registered outputs are stable afterwards.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
      wr_ready = 1'b1;

      // Reset held two cycles with both requesters active
      tick(); tick();
      #1;
      check("rst_ready", {req1_ready, req0_ready}, 2'b00);
      check("rst_wr_valid", wr_valid, 1'b0);
      check("rst_wr_addr", wr_addr, 5'd0);
      check("rst_cnt", conflict_cnt, 8'd0);
      check("rst_mux_op", mux_op, 1'b0);
      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // Single req0 write
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEAD_BEEF;
      #1;
      check("single_r0_ready", {req1_ready, req0_ready}, 2'b01);
      check("single_mux_op", mux_op, 1'b0);
      tick();
      check("single_wr_valid", wr_valid, 1'b1);
      check("single_wr_addr", wr_addr, 5'd3);
      check("single_wr_data", wr_data, 32'hDEAD_BEEF);
      req0_valid = 1'b0;
      tick();
      check("single_retire", wr_valid, 1'b0);
      check("single_cnt", conflict_cnt, 8'd0);

      // Single req1 write; mux_op then holds 1 through an idle cycle
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h1234_5678;
      #1;
      check("r1_ready", {req1_ready, req0_ready}, 2'b10);
      check("r1_mux_op", mux_op, 1'b1);
      tick();
      check("r1_wr_addr", wr_addr, 5'd9);
      check("r1_wr_data", wr_data, 32'h1234_5678);
      req1_valid = 1'b0;
      #1;
      check("mux_op_hold", mux_op, 1'b1);
      tick();

      // Contention: last grant was req1, so grants alternate 0,1,0,1
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA1;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB2;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("cont_ready_%0d", k), {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("cont_mux_op_%0d", k), mux_op, (k % 2 == 0) ? 1'b0 : 1'b1);
         tick();
         check($sformatf("cont_wr_addr_%0d", k), wr_addr, (k % 2 == 0) ? 5'd1 : 5'd2);
         check($sformatf("cont_wr_data_%0d", k), wr_data, (k % 2 == 0) ? 32'hA1 : 32'hB2);
      end
      check("cont_cnt", conflict_cnt, 8'd4);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      check("cont_retire", wr_valid, 1'b0);

      // Backpressure on a write to reg 7, then release with req1 waiting
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
      #1;
      check("bp_r0_ready", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
      wr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_r1_stall_%0d", k), req1_ready, 1'b0);
         tick();
         check($sformatf("bp_hold_valid_%0d", k), wr_valid, 1'b1);
         check($sformatf("bp_hold_addr_%0d", k), wr_addr, 5'd7);
         check($sformatf("bp_hold_data_%0d", k), wr_data, 32'h77);
      end
      wr_ready = 1'b1;
      #1;
      check("bp_release_ready", req1_ready, 1'b1);
      tick();
      check("bp_next_valid", wr_valid, 1'b1);
      check("bp_next_addr", wr_addr, 5'd8);
      check("bp_next_data", wr_data, 32'h88);
      req1_valid = 1'b0;
      tick();
      check("bp_retire", wr_valid, 1'b0);

      // Write to $zero: accepted, no write, and last grant moves to req1
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFF;
      #1;
      check("zero_r1_ready", req1_ready, 1'b1);
      tick();
      check("zero_no_write", wr_valid, 1'b0);
      req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
      req1_addr = 5'd5; req1_data = 32'h55;
      #1;
      check("zero_tie_to_r0", {req1_ready, req0_ready}, 2'b01);
      tick();
      check("zero_tie_addr", wr_addr, 5'd4);
      req0_valid = 1'b0;
      #1;
      check("zero_r1_follow", req1_ready, 1'b1);
      tick();
      check("zero_r1_addr", wr_addr, 5'd5);
      check("zero_r1_data", wr_data, 32'h55);
      req1_valid = 1'b0;
      tick();
      check("zero_retire", wr_valid, 1'b0);
      check("zero_cnt", conflict_cnt, 8'd5);

      // Saturation under sustained contention with the write port blocked
      req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA;
      req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hB;
      wr_ready = 1'b0;
      repeat (260) tick();
      check("sat_cnt", conflict_cnt, 8'd255);
      check("sat_pend", wr_valid, 1'b1);
      #1;
      check("sat_ready", {req1_ready, req0_ready}, 2'b00);

      // Reset while a write is pending drops it
      reset = 1'b1;
      tick();
      check("rst_pend_valid", wr_valid, 1'b0);
      check("rst_pend_cnt", conflict_cnt, 8'd0);
      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
